// File: rtl/apb_mem_pkg.sv
// Shared types and helpers for the APB-to-memory controller.
// State encoding, byte-lane alignment and counter sizing.
package apb_mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_RESP,
    S_ERR
  } state_t;

  function automatic int align_of(input int dw);
    return $clog2(dw / 8);
  endfunction

  function automatic int cnt_w(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/apb_mem_addr_chk.sv
// Byte-address decode into a memory word index.
// Flags misaligned or out-of-range addresses.
module apb_mem_addr_chk
  import apb_mem_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16
) (
  input  logic [APB_ADDR_WIDTH-1:0] i_paddr,
  output logic [ADDR_WIDTH-1:0]     o_word,
  output logic                      o_err
);

  localparam int ALIGN = align_of(DATA_WIDTH);
  localparam int TOP   = ADDR_WIDTH + ALIGN;

  localparam logic [APB_ADDR_WIDTH-1:0] LMASK =
    {APB_ADDR_WIDTH{1'b1}} >> (APB_ADDR_WIDTH - ALIGN);

  logic [APB_ADDR_WIDTH-1:0] hi;
  logic [APB_ADDR_WIDTH-1:0] lo;

  assign o_word = i_paddr[TOP-1:ALIGN];
  assign hi     = i_paddr >> TOP;
  assign lo     = i_paddr & LMASK;
  assign o_err  = (|hi) | (|lo);

endmodule

// File: rtl/apb_mem_ctrl.sv
// APB3 slave sequencing a registered single-port memory.
// Moore FSM: strobes, read wait states, error responses.
module apb_mem_ctrl
  import apb_mem_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int RD_LATENCY     = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_psel,
  input  logic                      i_penable,
  input  logic                      i_pwrite,
  input  logic [APB_ADDR_WIDTH-1:0] i_paddr,
  input  logic [DATA_WIDTH-1:0]     i_pwdata,
  output logic [DATA_WIDTH-1:0]     o_prdata,
  output logic                      o_pready,
  output logic                      o_pslverr,
  output logic                      o_mem_en,
  output logic                      o_mem_wr,
  output logic [ADDR_WIDTH-1:0]     o_mem_addr,
  output logic [DATA_WIDTH-1:0]     o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]     i_mem_rdata
);

  localparam int CW = cnt_w(RD_LATENCY);
  localparam logic [CW-1:0] CNT_LD = CW'(RD_LATENCY - 1);

  logic [ADDR_WIDTH-1:0] word;
  logic                  bad;
  logic                  setup;
  state_t                state;
  logic [CW-1:0]         cnt;

  apb_mem_addr_chk #(
    .APB_ADDR_WIDTH(APB_ADDR_WIDTH),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_chk (
    .i_paddr(i_paddr),
    .o_word (word),
    .o_err  (bad)
  );

  assign setup = i_psel & ~i_penable;

  // Transfer sequencer; strobes and responses are single-cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      o_prdata    <= '0;
      o_pready    <= 1'b0;
      o_pslverr   <= 1'b0;
      o_mem_en    <= 1'b0;
      o_mem_wr    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else begin
      o_mem_en  <= 1'b0;
      o_mem_wr  <= 1'b0;
      o_pready  <= 1'b0;
      o_pslverr <= 1'b0;
      unique case (state)
        S_IDLE: begin
          o_prdata <= '0;
          if (setup) begin
            if (bad) begin
              state     <= S_ERR;
              o_pready  <= 1'b1;
              o_pslverr <= 1'b1;
            end else if (i_pwrite) begin
              state       <= S_WR;
              o_mem_en    <= 1'b1;
              o_mem_wr    <= 1'b1;
              o_mem_addr  <= word;
              o_mem_wdata <= i_pwdata;
              o_pready    <= 1'b1;
            end else begin
              state      <= S_RD_ISSUE;
              o_mem_en   <= 1'b1;
              o_mem_addr <= word;
            end
          end
        end
        S_RD_ISSUE: begin
          if (!i_psel) begin
            state <= S_IDLE;
          end else begin
            state <= S_RD_WAIT;
            cnt   <= CNT_LD;
          end
        end
        S_RD_WAIT: begin
          if (!i_psel) begin
            state <= S_IDLE;
          end else if (cnt == '0) begin
            state    <= S_RD_RESP;
            o_prdata <= i_mem_rdata;
            o_pready <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RD_RESP: begin
          state    <= S_IDLE;
          o_prdata <= '0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/apb_mem_ctrl.md
Name: apb_mem_ctrl

Overview:
APB3 slave controller that sequences accesses to the synchronous single-port memory block (Memory_model). It converts APB setup/access phases into single-cycle memory enable/write strobes and absorbs the memory's registered read latency with PREADY wait states. It also range- and alignment-checks each address, answering with PSLVERR and issuing no memory access on a bad address. It sits between the APB interconnect and one memory instance.

Parameters:
APB_ADDR_WIDTH, 32, width of i_paddr (byte address)
ADDR_WIDTH, 16, memory word-address width; depth = 2^ADDR_WIDTH words
DATA_WIDTH, 16, APB and memory data width; must be a multiple of 8
RD_LATENCY, 1, memory cycles from enable to valid o_data_r; must be >= 1

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rst  in  1  synchronous reset, active-high
i_psel  in  1  APB select
i_penable  in  1  APB enable (access phase)
i_pwrite  in  1  1 = write, 0 = read
i_paddr  in  APB_ADDR_WIDTH  byte address
i_pwdata  in  DATA_WIDTH  write data
o_prdata  out  DATA_WIDTH  read data; valid only while o_pready=1 on a read
o_pready  out  1  transfer complete
o_pslverr  out  1  error response; valid only with o_pready
o_mem_en  out  1  to memory i_en
o_mem_wr  out  1  to memory i_wr
o_mem_addr  out  ADDR_WIDTH  to memory i_addr
o_mem_wdata  out  DATA_WIDTH  to memory i_data_w
i_mem_rdata  in  DATA_WIDTH  from memory o_data_r

Behaviour:
- One clock (i_clk); reset i_rst is synchronous and active-high. On a reset edge: state=IDLE, every output 0, latency counter 0. This applies mid-transfer too: any in-flight response is dropped.
- All outputs are registered (Moore). There is no combinational path from APB inputs to outputs.
- ALIGN = log2(DATA_WIDTH/8).
  - Word index = i_paddr[ADDR_WIDTH+ALIGN-1:ALIGN].
  - Error when i_paddr[ALIGN-1:0] != 0 or any i_paddr bit at or above ADDR_WIDTH+ALIGN is set.
- States:
  - IDLE: wait for setup phase (i_psel=1, i_penable=0). At that edge, latch address/data and decode:
    - bad address -> ERR
    - good address, i_pwrite=1 -> WR (o_mem_en=o_mem_wr=1, o_mem_addr/o_mem_wdata loaded)
    - good address, i_pwrite=0 -> RD_ISSUE (o_mem_en=1, o_mem_wr=0, o_mem_addr loaded)
  - WR: the strobe is high for exactly this one cycle, with o_pready=1 in the same cycle. Write completes in the first access cycle (0 wait states). Next state IDLE.
  - RD_ISSUE: memory enable high for one cycle. Next state RD_WAIT, with the counter loaded to RD_LATENCY-1.
  - RD_WAIT: o_mem_en=0. When the counter is 0, capture i_mem_rdata into o_prdata and go to RD_RESP. Otherwise decrement.
  - RD_RESP: o_pready=1, o_prdata held. Next state IDLE.
  - ERR: o_pready=1, o_pslverr=1, o_prdata=0. No memory strobe at any time. Next state IDLE.
- Read timeline for RD_LATENCY=1, with T0 = setup phase:
  - o_mem_en high in T1
  - data captured at end of T2
  - o_pready high in T3 (2 wait states)
  - In general, the number of wait states is RD_LATENCY+1.
- o_mem_en/o_mem_wr are single-cycle pulses; they are never high outside WR/RD_ISSUE.
- o_pready and o_pslverr deassert the cycle after a response.
- Protocol violation: i_psel=0 in any non-IDLE state -> return to IDLE next edge with no response.
  - A memory strobe already issued still completes.
  - Read data is discarded.
- Setup phase asserted while not IDLE: ignored. APB guarantees a setup phase precedes every access, so back-to-back transfers always re-enter through IDLE.
- o_mem_addr/o_mem_wdata hold their last value between accesses.

Decomposition:
- Package apb_mem_pkg:
  - state encoding (IDLE, WR, RD_ISSUE, RD_WAIT, RD_RESP, ERR)
  - ALIGN derivation constant/function
  - counter width clog2(RD_LATENCY+1)
- One natural sub-module: apb_mem_addr_chk, which is pure decode from i_paddr to word index plus error flag. The FSM, counter and response registers stay in apb_mem_ctrl.

Test Plan:
- Reset for 2 cycles with i_psel=1 held -> all outputs 0; no o_mem_en pulse while reset is high.
- Write 0xBEEF to i_paddr=0x0000_0010 -> o_mem_en=o_mem_wr=1 for one cycle with o_mem_addr=0x0008 and o_mem_wdata=0xBEEF; o_pready=1 in that same first access cycle; o_pslverr=0.
- Read i_paddr=0x0000_0010, with the memory model returning 0xBEEF, RD_LATENCY=1 -> o_mem_en=1, o_mem_wr=0 in T1; o_pready=1 in T3 with o_prdata=0xBEEF. Repeat with RD_LATENCY=3 -> o_pready in T5.
- Read i_paddr=0x0002_0000 (out of range) and i_paddr=0x0000_0003 (misaligned) -> o_pready=o_pslverr=1 in T1, o_prdata=0, o_mem_en never asserted.
- Back-to-back write 0x1234 @0x0, then read @0x0 -> read returns 0x1234; exactly one o_mem_en pulse per transfer.
- Drop i_psel during RD_WAIT, then assert i_rst during RD_RESP of a later read -> the first read gives no o_pready; after reset, o_pready=0 and state is IDLE, and the next write completes normally.
